au_dec_cnt: RTL and testbench

Loadable, tick-enabled down-counter: the sequential stage that wraps the library decrementer AU_dec. It holds the current count in a register, feeds it to the decrementer, and registers the decremented result back on every enabled tick. It reports terminal count with auto-reload for periodic operation. Used as the programmable interval/timeout counter in front of downstream control logic.

---
 rtl/au_dec_cnt_if.sv | 25 ++
 rtl/au_dec_cnt.sv | 137 +++++++++++++
 tb/tb_au_dec_cnt.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/au_dec_cnt_if.sv
// Control/status bundle for the au_dec_cnt interval counter.
// master drives the controls and observes status; slave is the counter side.
interface au_dec_cnt_if #(
  parameter int WIDTH = 8
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             stop;
  logic             mode;
  logic             en;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc;

  modport master (
    output load, load_val, start, stop, mode, en,
    input  count, busy, tc
  );

  modport slave (
    input  load, load_val, start, stop, mode, en,
    output count, busy, tc
  );
endinterface

// File: rtl/au_dec_cnt.sv
// Loadable, tick-enabled down-counter with terminal-count pulse and optional
// auto-reload, built around the AU_dec decrementer (selectable architecture).

module AU_dec #(
  parameter int WIDTH = 8,
  parameter int ARCH  = 0
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] z
);
  // The borrow into bit i is set when every lower bit of a is zero;
  // the architectures differ only in how that AND-chain is formed.
  generate
    if (ARCH == 1) begin : g_lookahead
      logic [WIDTH-1:0] bw;
      always_comb begin
        bw = '0;
        for (int unsigned i = 0; i < WIDTH; i++)
          bw[i] = ~|(a & ~({WIDTH{1'b1}} << i));
        z = a ^ bw;
      end
    end else if (ARCH == 2) begin : g_prefix
      logic [WIDTH-1:0] p;
      logic [WIDTH-1:0] bw;
      always_comb begin
        p = ~a;
        for (int unsigned s = 1; s < WIDTH; s = s * 2)
          p = p & ((p << s) | ~({WIDTH{1'b1}} << s));
        bw = (p << 1) | WIDTH'(1);
        z  = a ^ bw;
      end
    end else begin : g_ripple
      logic b;
      always_comb begin
        b = 1'b1;
        z = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
          z[i] = a[i] ^ b;
          b    = b & ~a[i];
        end
      end
    end
  endgenerate
endmodule

module au_dec_cnt #(
  parameter int WIDTH = 8,
  parameter int ARCH  = 0
) (
  input  logic          clk,
  input  logic          rst,
  au_dec_cnt_if.slave   bus
);
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] reload;
  logic             mode_r;
  logic             busy_r;
  logic             tc_r;
  logic [WIDTH-1:0] cnt_dec;
  logic [WIDTH-1:0] eff_cnt;
  logic             terminal;

  AU_dec #(
    .WIDTH (WIDTH),
    .ARCH  (ARCH)
  ) u_dec (
    .a (cnt),
    .z (cnt_dec)
  );

  assign eff_cnt  = bus.load ? bus.load_val : cnt;
  assign terminal = (cnt <= WIDTH'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      reload <= '0;
      mode_r <= 1'b0;
      busy_r <= 1'b0;
      tc_r   <= 1'b0;
    end else begin
      tc_r <= 1'b0;
      if (bus.load) begin
        cnt    <= bus.load_val;
        reload <= bus.load_val;
      end
      case (state)
        IDLE: begin
          // stop outranks start even though stop alone does nothing here
          if (bus.start && !bus.stop) begin
            if (eff_cnt == '0) begin
              tc_r <= 1'b1;
            end else begin
              state  <= RUN;
              busy_r <= 1'b1;
              mode_r <= bus.mode;
            end
          end
        end
        RUN: begin
          if (bus.stop) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end else if (bus.en && !bus.load) begin
            if (terminal) begin
              tc_r <= 1'b1;
              if (mode_r) begin
                cnt <= reload;
              end else begin
                cnt    <= '0;
                state  <= IDLE;
                busy_r <= 1'b0;
              end
            end else begin
              cnt <= cnt_dec;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.count = cnt;
  assign bus.busy  = busy_r;
  assign bus.tc    = tc_r;
endmodule

// File: tb/tb_au_dec_cnt.sv
// Directed bench for au_dec_cnt: hand-computed expectations checked with
// immediate assertions one cycle after each stimulus edge.
module tb_au_dec_cnt;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  au_dec_cnt_if #(.WIDTH(WIDTH)) bus ();

  au_dec_cnt #(
    .WIDTH (WIDTH),
    .ARCH  (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [WIDTH-1:0] c, input logic b, input logic t);
    chk({tag, ".count"}, 32'(bus.count), 32'(c));
    chk({tag, ".busy"},  32'(bus.busy),  32'(b));
    chk({tag, ".tc"},    32'(bus.tc),    32'(t));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.load = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.en = 1'b0;
  endtask

  logic [WIDTH-1:0] per_cnt [10];
  logic             per_tc  [10];
  logic             en_pat  [7];
  logic [WIDTH-1:0] en_cnt  [7];

  initial begin
    per_cnt = '{8'd2, 8'd1, 8'd3, 8'd2, 8'd1, 8'd3, 8'd2, 8'd1, 8'd3, 8'd2};
    per_tc  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    en_pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    en_cnt  = '{8'd3, 8'd3, 8'd3, 8'd2, 8'd1, 8'd1, 8'd0};

    idle_in();
    bus.load_val = '0;
    bus.mode     = 1'b0;
    #12;
    chk_all("reset", 8'd0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    chk_all("post_reset", 8'd0, 1'b0, 1'b0);

    // One-shot from 5
    bus.load = 1'b1; bus.load_val = 8'd5; step(); idle_in();
    chk_all("os_load", 8'd5, 1'b0, 1'b0);
    bus.start = 1'b1; bus.mode = 1'b0; bus.en = 1'b1; step(); bus.start = 1'b0;
    chk_all("os_start", 8'd5, 1'b1, 1'b0);
    for (int k = 4; k >= 1; k--) begin
      step();
      chk_all("os_tick", 8'(k), 1'b1, 1'b0);
    end
    step();
    chk_all("os_term", 8'd0, 1'b0, 1'b1);
    step();
    chk_all("os_after", 8'd0, 1'b0, 1'b0);
    idle_in();

    // Periodic with reload 3, then stop
    bus.load = 1'b1; bus.load_val = 8'd3; step(); idle_in();
    bus.start = 1'b1; bus.mode = 1'b1; bus.en = 1'b1; step(); bus.start = 1'b0;
    chk_all("per_start", 8'd3, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step();
      chk_all("per_tick", per_cnt[k], 1'b1, per_tc[k]);
    end
    bus.stop = 1'b1; step(); bus.stop = 1'b0;
    chk_all("per_stop", 8'd2, 1'b0, 1'b0);
    step();
    chk_all("per_frozen", 8'd2, 1'b0, 1'b0);
    idle_in();

    // Gated enable pattern, one-shot from 4
    bus.load = 1'b1; bus.load_val = 8'd4; bus.mode = 1'b0; step(); idle_in();
    bus.start = 1'b1; step(); bus.start = 1'b0;
    chk_all("en_start", 8'd4, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) begin
      bus.en = en_pat[k];
      step();
      chk_all("en_pat", en_cnt[k], (k != 6), (k == 6));
    end
    idle_in();

    // Stop after two ticks, restart resumes from 2
    bus.load = 1'b1; bus.load_val = 8'd4; step(); idle_in();
    bus.start = 1'b1; step(); bus.start = 1'b0;
    bus.en = 1'b1; step();
    chk_all("rs_t1", 8'd3, 1'b1, 1'b0);
    step();
    chk_all("rs_t2", 8'd2, 1'b1, 1'b0);
    bus.stop = 1'b1; step(); bus.stop = 1'b0;
    chk_all("rs_stop", 8'd2, 1'b0, 1'b0);
    bus.start = 1'b1; step(); bus.start = 1'b0;
    chk_all("rs_restart", 8'd2, 1'b1, 1'b0);
    step();
    chk_all("rs_t3", 8'd1, 1'b1, 1'b0);
    step();
    chk_all("rs_term", 8'd0, 1'b0, 1'b1);
    idle_in();

    // Start with zero count, then start together with load 0
    bus.start = 1'b1; step(); bus.start = 1'b0;
    chk_all("z_start", 8'd0, 1'b0, 1'b1);
    step();
    chk_all("z_after", 8'd0, 1'b0, 1'b0);
    bus.load = 1'b1; bus.load_val = 8'd6; step(); idle_in();
    bus.load = 1'b1; bus.load_val = 8'd0; bus.start = 1'b1; step(); idle_in();
    chk_all("z_ldstart", 8'd0, 1'b0, 1'b1);
    step();
    chk_all("z_ldafter", 8'd0, 1'b0, 1'b0);

    // Periodic RUN, reload set to 0 -> tc on every enabled tick
    bus.load = 1'b1; bus.load_val = 8'd2; step(); idle_in();
    bus.start = 1'b1; bus.mode = 1'b1; step(); bus.start = 1'b0;
    chk_all("p0_start", 8'd2, 1'b1, 1'b0);
    bus.load = 1'b1; bus.load_val = 8'd0; bus.en = 1'b1; step(); bus.load = 1'b0;
    chk_all("p0_load", 8'd0, 1'b1, 1'b0);
    step();
    chk_all("p0_t1", 8'd0, 1'b1, 1'b1);
    step();
    chk_all("p0_t2", 8'd0, 1'b1, 1'b1);
    bus.en = 1'b0; step();
    chk_all("p0_hold", 8'd0, 1'b1, 1'b0);
    bus.en = 1'b1; step();
    chk_all("p0_t3", 8'd0, 1'b1, 1'b1);
    idle_in();
    bus.stop = 1'b1; step(); idle_in();
    chk_all("p0_stop", 8'd0, 1'b0, 1'b0);

    // Full-range one-shot from 8'hFF
    bus.load = 1'b1; bus.load_val = 8'hFF; bus.mode = 1'b0; step(); idle_in();
    bus.start = 1'b1; bus.en = 1'b1; step(); bus.start = 1'b0;
    chk_all("ff_start", 8'hFF, 1'b1, 1'b0);
    for (int k = 1; k <= 254; k++) begin
      step();
      chk_all("ff_tick", 8'(255 - k), 1'b1, 1'b0);
    end
    step();
    chk_all("ff_term", 8'd0, 1'b0, 1'b1);
    step();
    chk_all("ff_after", 8'd0, 1'b0, 1'b0);
    idle_in();

    // Asynchronous reset mid-run at tick 100
    bus.load = 1'b1; bus.load_val = 8'hFF; step(); idle_in();
    bus.start = 1'b1; bus.en = 1'b1; step(); bus.start = 1'b0;
    for (int k = 1; k <= 100; k++) step();
    chk_all("ar_pre", 8'd155, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    chk_all("ar_async", 8'd0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    idle_in();
    step();
    chk_all("ar_post", 8'd0, 1'b0, 1'b0);

    // Load and stop in the same RUN cycle; start+stop in IDLE
    bus.load = 1'b1; bus.load_val = 8'd7; step(); idle_in();
    bus.start = 1'b1; step(); idle_in();
    chk_all("ls_run", 8'd7, 1'b1, 1'b0);
    bus.load = 1'b1; bus.load_val = 8'd2; bus.stop = 1'b1; bus.en = 1'b1; step(); idle_in();
    chk_all("ls_both", 8'd2, 1'b0, 1'b0);
    bus.start = 1'b1; bus.stop = 1'b1; bus.en = 1'b1; step(); idle_in();
    chk_all("ss_idle", 8'd2, 1'b0, 1'b0);
    step();
    chk_all("ss_after", 8'd2, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
